// File: rtl/wavegen_pkg.sv
// rtl/wavegen_pkg.sv - shared encodings and width helpers for the waveform generator
//
// Contents:
//   N_FRAC_DEFAULT, CNT_W_DEFAULT  default fractional width / square counter width
//   sample_width()                 sample width W for a given fractional width
//   mode_t                         waveform select encodings
//   dir_t                          triangle direction encodings
package wavegen_pkg;

  localparam int N_FRAC_DEFAULT = 7;
  localparam int CNT_W_DEFAULT  = 8;

  // One sign bit on top of the fractional bits.
  function automatic int sample_width(input int n_frac);
    return n_frac + 1;
  endfunction

  typedef enum logic [1:0] {
    MODE_REFLECT = 2'd0,
    MODE_SAW     = 2'd1,
    MODE_TRI     = 2'd2,
    MODE_SQUARE  = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

endpackage

// File: rtl/wavegen_next_sample.sv
// rtl/wavegen_next_sample.sv - combinational next-sample step for reflect, saw and triangle shapes
//
// Optional build macro: WAVEGEN_WRAP_FLAG_EN (adds the wrap output).
//
// Ports:
//   mode        in   active waveform mode
//   sample      in   current sample (signed, W bits)
//   dir         in   current triangle direction
//   amp         in   clamped amplitude A (non-negative, W bits)
//   step        in   increment per strobe (unsigned, W-1 bits)
//   sample_nxt  out  next sample
//   dir_nxt     out  next triangle direction
//   wrap        out  start-of-period flag (only with WAVEGEN_WRAP_FLAG_EN)
//
// The square shape needs the half-period counter, so it is produced by
// wavegen_core; for MODE_SQUARE this block simply holds the sample.
module wavegen_next_sample
  import wavegen_pkg::*;
#(
  parameter int W = 8
) (
  input  mode_t                mode,
  input  logic signed [W-1:0]  sample,
  input  dir_t                 dir,
  input  logic signed [W-1:0]  amp,
  input  logic        [W-2:0]  step,
  output logic signed [W-1:0]  sample_nxt,
  output dir_t                 dir_nxt
`ifdef WAVEGEN_WRAP_FLAG_EN
  ,
  output logic                 wrap
`endif
);

  // One guard bit so sums/differences cannot overflow before the clamp compare.
  logic signed [W:0] sample_ext;
  logic signed [W:0] amp_ext;
  logic signed [W:0] neg_amp_ext;
  logic signed [W:0] sum_ext;
  logic signed [W:0] diff_ext;

  assign sample_ext  = {sample[W-1], sample};
  assign amp_ext     = {amp[W-1], amp};
  assign neg_amp_ext = -amp_ext;
  assign sum_ext     = sample_ext + $signed({2'b00, step});
  assign diff_ext    = sample_ext - $signed({2'b00, step});

  always_comb begin
    sample_nxt = sample;
    dir_nxt    = dir;
    case (mode)
      MODE_REFLECT: begin
        // Legacy behaviour: plain W-bit wrapping add, negate once above A.
        if (sample <= amp) begin
          sample_nxt = sum_ext[W-1:0];
        end else begin
          sample_nxt = -sample;
        end
      end
      MODE_SAW: begin
        if (sum_ext > amp_ext) begin
          sample_nxt = neg_amp_ext[W-1:0];
        end else begin
          sample_nxt = sum_ext[W-1:0];
        end
      end
      MODE_TRI: begin
        if (dir == DIR_UP) begin
          if (sum_ext >= amp_ext) begin
            sample_nxt = amp;
            dir_nxt    = DIR_DOWN;
          end else begin
            sample_nxt = sum_ext[W-1:0];
          end
        end else begin
          if (diff_ext <= neg_amp_ext) begin
            sample_nxt = neg_amp_ext[W-1:0];
            dir_nxt    = DIR_UP;
          end else begin
            sample_nxt = diff_ext[W-1:0];
          end
        end
      end
      default: begin
        sample_nxt = sample;
      end
    endcase
  end

`ifdef WAVEGEN_WRAP_FLAG_EN
  assign wrap = ((mode == MODE_REFLECT) && !(sample <= amp)) ||
                ((mode == MODE_SAW) && (sum_ext > amp_ext)) ||
                ((mode == MODE_TRI) && (dir == DIR_DOWN) && (diff_ext <= neg_amp_ext));
`endif

endmodule

// File: rtl/wavegen_core.sv
// rtl/wavegen_core.sv - strobe-driven multi-mode waveform generator (reflect, saw, triangle, square)
//
// Optional build macro: WAVEGEN_WRAP_FLAG_EN (adds wrap_o).
//
// Ports:
//   clk_i                    in   clock
//   rst_i                    in   asynchronous active-high reset
//   mode_i                   in   waveform select (0 reflect, 1 saw, 2 tri, 3 square)
//   amplitude_i              in   signed peak magnitude, negatives clamp to 0
//   step_i                   in   unsigned increment per strobe
//   half_period_i            in   strobes per square half-cycle, 0 acts as 1
//   clear_i                  in   synchronous clear of generator state (wins over strobe)
//   next_data_strobe_i       in   request for the next sample
//   data_o                   out  registered signed sample
//   data_out_valid_strobe_o  out  one-cycle pulse after each accepted strobe
//   wrap_o                   out  start-of-period pulse aligned with valid (optional)
module wavegen_core
  import wavegen_pkg::*;
#(
  parameter  int N_FRAC = N_FRAC_DEFAULT,
  parameter  int CNT_W  = CNT_W_DEFAULT,
  localparam int W      = sample_width(N_FRAC)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [1:0]          mode_i,
  input  logic signed [W-1:0] amplitude_i,
  input  logic [N_FRAC-1:0]   step_i,
  input  logic [CNT_W-1:0]    half_period_i,
  input  logic                clear_i,
  input  logic                next_data_strobe_i,
  output logic signed [W-1:0] data_o,
  output logic                data_out_valid_strobe_o
`ifdef WAVEGEN_WRAP_FLAG_EN
  ,
  output logic                wrap_o
`endif
);

  mode_t             active_mode_q, active_mode_d;
  mode_t             mode_req;
  dir_t              dir_q, dir_d;
  logic [CNT_W-1:0]  sq_cnt_q, sq_cnt_d;
  logic              sq_level_q, sq_level_d;
  logic signed [W-1:0] data_d;
  logic              valid_d;

  logic signed [W-1:0] amp;
  logic [CNT_W-1:0]  half_eff;
  logic              sq_terminal;
  logic              mode_change;

  logic signed [W-1:0] ns_sample;
  dir_t              ns_dir;

  assign mode_req    = mode_t'(mode_i);
  assign mode_change = (mode_req != active_mode_q);
  assign amp         = amplitude_i[W-1] ? '0 : amplitude_i;
  assign half_eff    = (half_period_i == '0) ? CNT_W'(1) : half_period_i;
  assign sq_terminal = (sq_cnt_q == half_eff - CNT_W'(1));

`ifdef WAVEGEN_WRAP_FLAG_EN
  logic ns_wrap;
  logic wrap_d;
`endif

  wavegen_next_sample #(
    .W (W)
  ) u_next_sample (
    .mode       (active_mode_q),
    .sample     (data_o),
    .dir        (dir_q),
    .amp        (amp),
    .step       (step_i),
    .sample_nxt (ns_sample),
    .dir_nxt    (ns_dir)
`ifdef WAVEGEN_WRAP_FLAG_EN
    ,
    .wrap       (ns_wrap)
`endif
  );

  always_comb begin
    active_mode_d = active_mode_q;
    dir_d         = dir_q;
    sq_cnt_d      = sq_cnt_q;
    sq_level_d    = sq_level_q;
    data_d        = data_o;
    valid_d       = 1'b0;
    if (clear_i) begin
      // Clear keeps the selected mode so the next strobe steps instead of re-arming.
      dir_d      = DIR_UP;
      sq_cnt_d   = '0;
      sq_level_d = 1'b0;
      data_d     = '0;
    end else if (next_data_strobe_i) begin
      valid_d = 1'b1;
      if (mode_change) begin
        // Re-arm into the new shape from zero; no step on this strobe.
        active_mode_d = mode_req;
        dir_d         = DIR_UP;
        sq_cnt_d      = '0;
        sq_level_d    = 1'b0;
        data_d        = '0;
      end else if (active_mode_q == MODE_SQUARE) begin
        data_d = sq_level_q ? amp : -amp;
        if (sq_terminal) begin
          // The toggled level is seen on the following sample.
          sq_cnt_d   = '0;
          sq_level_d = ~sq_level_q;
        end else begin
          sq_cnt_d = sq_cnt_q + CNT_W'(1);
        end
      end else begin
        data_d = ns_sample;
        dir_d  = ns_dir;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      active_mode_q           <= MODE_REFLECT;
      dir_q                   <= DIR_UP;
      sq_cnt_q                <= '0;
      sq_level_q              <= 1'b0;
      data_o                  <= '0;
      data_out_valid_strobe_o <= 1'b0;
    end else begin
      active_mode_q           <= active_mode_d;
      dir_q                   <= dir_d;
      sq_cnt_q                <= sq_cnt_d;
      sq_level_q              <= sq_level_d;
      data_o                  <= data_d;
      data_out_valid_strobe_o <= valid_d;
    end
  end

`ifdef WAVEGEN_WRAP_FLAG_EN
  // Square "wrap" is the low-to-high toggle; other shapes report their own period start.
  assign wrap_d = !clear_i && next_data_strobe_i && !mode_change &&
                  ((active_mode_q == MODE_SQUARE) ? (sq_terminal && !sq_level_q) : ns_wrap);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wrap_o <= 1'b0;
    end else begin
      wrap_o <= wrap_d;
    end
  end
`endif

endmodule

// File: tb/tb_wavegen_core.sv
// tb/tb_wavegen_core.sv - directed self-checking bench for wavegen_core
module tb_wavegen_core;

  logic              clk;
  logic              rst;
  logic [1:0]        mode;
  logic signed [7:0] amp;
  logic [6:0]        step;
  logic [7:0]        hp;
  logic              clear;
  logic              strobe;
  logic signed [7:0] data_o;
  logic              valid;
`ifdef WAVEGEN_WRAP_FLAG_EN
  logic              wrap;
`endif

  int checks   = 0;
  int failures = 0;

  wavegen_core dut (
    .clk_i                   (clk),
    .rst_i                   (rst),
    .mode_i                  (mode),
    .amplitude_i             (amp),
    .step_i                  (step),
    .half_period_i           (hp),
    .clear_i                 (clear),
    .next_data_strobe_i      (strobe),
    .data_o                  (data_o),
    .data_out_valid_strobe_o (valid)
`ifdef WAVEGEN_WRAP_FLAG_EN
    ,
    .wrap_o                  (wrap)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Strobe for one cycle; returns on the falling edge right after the sampling edge.
  task automatic do_strobe;
    @(negedge clk);
    strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (data_o !== 8'sd0) begin
      failures++;
      $display("FAIL reset_data: got %0d want 0", data_o);
    end
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid: got %0b want 0", valid);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_saw;
    int exp [9];
    int got;
    exp = '{4, 8, -10, -6, -2, 2, 6, 10, -10};
    mode = 2'd1; amp = 8'sd10; step = 7'd4; hp = 8'd1;
    do_strobe;
    checks++;
    if (data_o !== 8'sd0 || valid !== 1'b1) begin
      failures++;
      $display("FAIL saw_mode_change: got data=%0d valid=%0b want data=0 valid=1", data_o, valid);
    end
    for (int i = 0; i < 9; i++) begin
      do_strobe;
      got = data_o;
      checks++;
      if (got !== exp[i]) begin
        failures++;
        $display("FAIL saw[%0d]: got %0d want %0d", i, got, exp[i]);
      end
      checks++;
      if (valid !== 1'b1) begin
        failures++;
        $display("FAIL saw_valid[%0d]: got %0b want 1", i, valid);
      end
      if (i == 0) begin
        @(negedge clk);
        checks++;
        if (valid !== 1'b0) begin
          failures++;
          $display("FAIL saw_valid_width: got %0b want 0", valid);
        end
      end
    end
  endtask

  task automatic test_tri;
    int exp [9];
    int got;
    exp = '{4, 8, 10, 6, 2, -2, -6, -10, -6};
    mode = 2'd2; amp = 8'sd10; step = 7'd4;
    do_strobe;
    checks++;
    if (data_o !== 8'sd0 || valid !== 1'b1) begin
      failures++;
      $display("FAIL tri_mode_change: got data=%0d valid=%0b want data=0 valid=1", data_o, valid);
    end
    for (int i = 0; i < 9; i++) begin
      do_strobe;
      got = data_o;
      checks++;
      if (got !== exp[i]) begin
        failures++;
        $display("FAIL tri[%0d]: got %0d want %0d", i, got, exp[i]);
      end
    end
  endtask

  task automatic test_hold;
    int got;
    @(negedge clk);
    @(negedge clk);
    got = data_o;
    checks++;
    if (got !== -6 || valid !== 1'b0) begin
      failures++;
      $display("FAIL hold: got data=%0d valid=%0b want data=-6 valid=0", got, valid);
    end
  endtask

  task automatic test_square;
    int exp [7];
    int alt [4];
    int got;
    exp = '{-50, -50, -50, 50, 50, 50, -50};
    alt = '{-50, 50, -50, 50};
    mode = 2'd3; amp = 8'sd50; hp = 8'd3;
    do_strobe;
    for (int i = 0; i < 7; i++) begin
      do_strobe;
      got = data_o;
      checks++;
      if (got !== exp[i]) begin
        failures++;
        $display("FAIL square[%0d]: got %0d want %0d", i, got, exp[i]);
      end
    end
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checks++;
    if (data_o !== 8'sd0) begin
      failures++;
      $display("FAIL square_clear: got %0d want 0", data_o);
    end
    hp = 8'd0;
    for (int i = 0; i < 4; i++) begin
      do_strobe;
      got = data_o;
      checks++;
      if (got !== alt[i]) begin
        failures++;
        $display("FAIL square_hp0[%0d]: got %0d want %0d", i, got, alt[i]);
      end
    end
  endtask

  task automatic test_reflect;
    int exp [6];
    int got;
    exp = '{60, 120, -120, -60, 0, 60};
    mode = 2'd0; amp = 8'sd100; step = 7'd60;
    do_strobe;
    for (int i = 0; i < 6; i++) begin
      do_strobe;
      got = data_o;
      checks++;
      if (got !== exp[i]) begin
        failures++;
        $display("FAIL reflect[%0d]: got %0d want %0d", i, got, exp[i]);
      end
    end
    mode = 2'd1; step = 7'd4;
    do_strobe;
    checks++;
    if (data_o !== 8'sd0 || valid !== 1'b1) begin
      failures++;
      $display("FAIL reflect_to_saw: got data=%0d valid=%0b want data=0 valid=1", data_o, valid);
    end
    do_strobe;
    got = data_o;
    checks++;
    if (got !== 4) begin
      failures++;
      $display("FAIL reflect_to_saw_step: got %0d want 4", got);
    end
  endtask

  task automatic test_clear_with_strobe;
    int got;
    @(negedge clk);
    clear = 1'b1;
    strobe = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    strobe = 1'b0;
    checks++;
    if (data_o !== 8'sd0 || valid !== 1'b0) begin
      failures++;
      $display("FAIL clear_strobe: got data=%0d valid=%0b want data=0 valid=0", data_o, valid);
    end
    do_strobe;
    got = data_o;
    checks++;
    if (got !== 4 || valid !== 1'b1) begin
      failures++;
      $display("FAIL clear_keeps_mode: got data=%0d valid=%0b want data=4 valid=1", got, valid);
    end
  endtask

  task automatic test_async_reset;
    int got;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (data_o !== 8'sd0) begin
      failures++;
      $display("FAIL async_reset: got %0d want 0", data_o);
    end
    @(negedge clk);
    rst = 1'b0;
    mode = 2'd0; amp = 8'sd100; step = 7'd4;
    do_strobe;
    got = data_o;
    checks++;
    if (got !== 4) begin
      failures++;
      $display("FAIL reset_mode_reflect: got %0d want 4", got);
    end
  endtask

  task automatic test_neg_amp;
    int got;
    mode = 2'd1; amp = -8'sd5; step = 7'd3;
    do_strobe;
`ifdef WAVEGEN_WRAP_FLAG_EN
    checks++;
    if (wrap !== 1'b0) begin
      failures++;
      $display("FAIL neg_amp_wrap_on_change: got %0b want 0", wrap);
    end
`endif
    for (int i = 0; i < 3; i++) begin
      do_strobe;
      got = data_o;
      checks++;
      if (got !== 0 || valid !== 1'b1) begin
        failures++;
        $display("FAIL neg_amp[%0d]: got data=%0d valid=%0b want data=0 valid=1", i, got, valid);
      end
`ifdef WAVEGEN_WRAP_FLAG_EN
      checks++;
      if (wrap !== 1'b1) begin
        failures++;
        $display("FAIL neg_amp_wrap[%0d]: got %0b want 1", i, wrap);
      end
`endif
    end
  endtask

  initial begin
    rst = 1'b1; mode = 2'd0; amp = 8'sd0; step = 7'd0; hp = 8'd1;
    clear = 1'b0; strobe = 1'b0;
    test_reset;
    test_saw;
    test_tri;
    test_hold;
    test_square;
    test_reflect;
    test_clear_with_strobe;
    test_async_reset;
    test_neg_amp;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
